pc_gen: RTL

Fetch-PC generator at the head of the frontend, directly upstream of `bpu`. It holds the fetch PC register and presents it to `bpu` and the icache through a valid/ready handshake. It steers the next PC by priority: backend redirect, then the `bpu` taken prediction returning one cycle after a fetch, then sequential fall-through. It also squashes the speculative sequential fetch that a late prediction overrides.

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_gen.sv | 91 +++++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// Shared frontend definitions: architectural width, fetch FSM states and boot PC.
package pc_gen_pkg;

    localparam int XLEN = 64;

    localparam logic [XLEN-1:0] PC_RESET_VECTOR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_gen.sv
// Fetch-PC generator: holds the fetch PC and steers it by redirect, late bpu
// prediction or sequential fall-through, killing the fetch a prediction overrides.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter int              FETCH_BYTES  = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic            pc_handshake,
    output logic            pc_kill,
    input  logic            predict_valid,
    input  logic [XLEN-1:0] trigger_pc,
    input  logic [XLEN-1:0] predict_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(FETCH_BYTES) - XLEN'(1));

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_seq;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_pc;
    logic            w_pred_hit;

    assign pc           = r_pc;
    assign pc_valid     = (r_state == RUN);
    assign pc_handshake = pc_valid & pc_ready;

    // A bpu result is only trusted for the fetch handshaken one cycle earlier.
    assign w_pred_hit = r_pend_valid & predict_valid & (trigger_pc == r_pend_pc) & ~redirect_valid;
    assign pc_kill    = w_pred_hit & pc_handshake;

    assign w_pc_seq = (r_pc & ALIGN_MASK) + XLEN'(FETCH_BYTES);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (redirect_valid) begin
            w_state_next = RUN;
            w_pc_next    = redirect_target;
        end else begin
            case (r_state)
                BOOT:    w_state_next = RUN;
                RUN:     w_state_next = halt_req ? HALT : RUN;
                HALT:    w_state_next = HALT;
                default: w_state_next = BOOT;
            endcase
            if (w_pred_hit) begin
                w_pc_next = predict_target;
            end else if (pc_handshake) begin
                w_pc_next = w_pc_seq;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // A killed handshake still records pend; the target fetch that follows clears it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else if (redirect_valid) begin
            r_pend_valid <= 1'b0;
        end else begin
            r_pend_valid <= pc_handshake;
            if (pc_handshake) begin
                r_pend_pc <= r_pc;
            end
        end
    end

endmodule
